// File: rtl/cpu_pkg.sv
// Shared definitions for the execute stage.
// Contents: multiply/divide operation encodings, the MDU state type,
// ALU operation codes and the forwarding-select constants.
package cpu_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MFHI  = 3'd6,
        MD_MFLO  = 3'd7
    } md_op_t;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_t;

    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_NOR  = 4'd4;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_SLTU = 4'd11;

    localparam int FWD_RF  = 0;
    localparam int FWD_MEM = 1;
    localparam int FWD_WB  = 2;

endpackage

// File: rtl/alu.sv
// Combinational ALU.
// Ports: a/b operands (WIDTH), op (4-bit ALU code), shamt (shift amount,
// applied to operand b), result (WIDTH).
module alu
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_ADD:  result = a + b;
            ALU_XOR:  result = a ^ b;
            ALU_NOR:  result = ~(a | b);
            ALU_SUB:  result = a - b;
            ALU_SLT:  result = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: result = {{(WIDTH-1){1'b0}}, a < b};
            ALU_SLL:  result = b << shamt;
            ALU_SRL:  result = b >> shamt;
            ALU_SRA:  result = $signed(b) >>> shamt;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Ports: clk, rst (sync, active-low), start/op (request), a/b (operands),
// flush (abort in-flight op), hi/lo (registered results), busy (RUN state).
// Multiply is shift-add, divide is restoring; both run on magnitudes and
// apply the sign fix-up in the same edge that writes HI/LO.
module md_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    md_state_t          state_reg;
    logic [CW-1:0]      cnt_reg;
    logic [2*WIDTH-1:0] acc_reg;   // mult: {partial, multiplier}; div: {rem, quotient}
    logic [WIDTH-1:0]   mag_reg;   // mult: multiplicand; div: divisor
    logic [WIDTH-1:0]   hi_reg, lo_reg;
    logic               is_div_reg, neg_q_reg, neg_r_reg;

    md_op_t op_e;
    assign op_e = md_op_t'(op);

    logic             is_signed, sign_a, sign_b, op_div;
    logic [WIDTH-1:0] mag_a, mag_b;
    assign is_signed = (op_e == MD_MULT) || (op_e == MD_DIV);
    assign op_div    = (op_e == MD_DIV)  || (op_e == MD_DIVU);
    assign sign_a    = is_signed & a[WIDTH-1];
    assign sign_b    = is_signed & b[WIDTH-1];
    assign mag_a     = sign_a ? -a : a;
    assign mag_b     = sign_b ? -b : b;

    // Multiply step: add multiplicand into the upper half when the
    // current multiplier bit is set, then shift the whole pair right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                    + (acc_reg[0] ? {1'b0, mag_reg} : {(WIDTH+1){1'b0}});
    assign mul_next = {mul_sum, acc_reg[WIDTH-1:1]};

    // Divide step: shift the next dividend bit into the remainder and
    // subtract the divisor if it fits. A zero divisor always "fits", which
    // yields an all-ones quotient and the dividend as remainder.
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_next;
    assign div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
    assign div_ge    = div_shift >= {1'b0, mag_reg};
    assign div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, mag_reg}) : div_shift[WIDTH-1:0];
    assign div_next  = {div_rem, acc_reg[WIDTH-2:0], div_ge};

    logic [2*WIDTH-1:0] step_next, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fin_hi, fin_lo;
    assign step_next = is_div_reg ? div_next : mul_next;
    assign prod_fix  = neg_q_reg ? -step_next : step_next;
    assign quo_fix   = neg_q_reg ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
    assign rem_fix   = neg_r_reg ? -step_next[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];
    assign fin_hi    = is_div_reg ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign fin_lo    = is_div_reg ? quo_fix : prod_fix[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= MD_IDLE;
            cnt_reg    <= '0;
            acc_reg    <= '0;
            mag_reg    <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
        end else if (flush) begin
            state_reg <= MD_IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                MD_IDLE: begin
                    if (start) begin
                        case (op_e)
                            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                state_reg  <= MD_RUN;
                                cnt_reg    <= '0;
                                is_div_reg <= op_div;
                                acc_reg    <= op_div ? {{WIDTH{1'b0}}, mag_a}
                                                     : {{WIDTH{1'b0}}, mag_b};
                                mag_reg    <= op_div ? mag_b : mag_a;
                                // Zero divisor keeps an unsigned all-ones quotient.
                                neg_q_reg  <= (sign_a ^ sign_b) & (b != '0);
                                neg_r_reg  <= sign_a & op_div;
                            end
                            MD_MTHI: hi_reg <= a;
                            MD_MTLO: lo_reg <= a;
                            default: ;
                        endcase
                    end
                end
                MD_RUN: begin
                    acc_reg <= step_next;
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CW'(WIDTH - 1)) begin
                        hi_reg    <= fin_hi;
                        lo_reg    <= fin_lo;
                        state_reg <= MD_IDLE;
                    end
                end
                default: state_reg <= MD_IDLE;
            endcase
        end
    end

    assign hi   = hi_reg;
    assign lo   = lo_reg;
    assign busy = (state_reg == MD_RUN);

endmodule

// File: rtl/execute_mdu.sv
// Execute stage: operand forwarding muxes, ALU-source mux, ALU and the
// iterative multiply/divide unit.
// Ports: clk, rst (sync, active-low); read_data1/2, fwd_data, fwd_sel_a/b,
// ext_imm, alu_src, alu_op, shamt (ALU path); md_start, md_op, flush (MDU
// control); alu_result, forward_b, md_busy, stall (outputs, unregistered).
module execute_mdu
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NFWD  = 2,
    parameter int SELW  = $clog2(NFWD + 1),
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     read_data1,
    input  logic [WIDTH-1:0]     read_data2,
    input  logic [NFWD*WIDTH-1:0] fwd_data,
    input  logic [SELW-1:0]      fwd_sel_a,
    input  logic [SELW-1:0]      fwd_sel_b,
    input  logic [WIDTH-1:0]     ext_imm,
    input  logic                 alu_src,
    input  logic [3:0]           alu_op,
    input  logic [SHW-1:0]       shamt,
    input  logic                 md_start,
    input  logic [2:0]           md_op,
    input  logic                 flush,
    output logic [WIDTH-1:0]     alu_result,
    output logic [WIDTH-1:0]     forward_b,
    output logic                 md_busy,
    output logic                 stall
);

    // Source 0 is the register file, source k is forwarding slot k-1.
    logic [WIDTH-1:0] src_a [0:NFWD];
    logic [WIDTH-1:0] src_b [0:NFWD];
    assign src_a[0] = read_data1;
    assign src_b[0] = read_data2;

    genvar gi;
    generate
        for (gi = 0; gi < NFWD; gi++) begin : g_fwd
            assign src_a[gi+1] = fwd_data[gi*WIDTH +: WIDTH];
            assign src_b[gi+1] = fwd_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Selects beyond the last source fall through to zero.
    logic [WIDTH-1:0] op_a, op_b;
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int k = 0; k <= NFWD; k++) begin
            if (fwd_sel_a == SELW'(k)) op_a = src_a[k];
            if (fwd_sel_b == SELW'(k)) op_b = src_b[k];
        end
    end

    logic [WIDTH-1:0] alu_b, alu_out, hi, lo;
    assign alu_b     = alu_src ? ext_imm : op_b;
    assign forward_b = op_b;

    alu #(.WIDTH(WIDTH), .SHW(SHW)) u_alu (
        .a      (op_a),
        .b      (alu_b),
        .op     (alu_op),
        .shamt  (shamt),
        .result (alu_out)
    );

    md_unit #(.WIDTH(WIDTH)) u_md (
        .clk   (clk),
        .rst   (rst),
        .start (md_start),
        .op    (md_op),
        .a     (op_a),
        .b     (op_b),
        .flush (flush),
        .hi    (hi),
        .lo    (lo),
        .busy  (md_busy)
    );

    md_op_t md_op_e;
    assign md_op_e = md_op_t'(md_op);

    always_comb begin
        alu_result = alu_out;
        if (md_start && md_op_e == MD_MFHI) alu_result = hi;
        if (md_start && md_op_e == MD_MFLO) alu_result = lo;
    end

    assign stall = md_busy & md_start;

endmodule

// File: doc/execute_mdu.md
# execute_mdu

Parametrised execute stage for the pipelined core. It carries the N-source operand forwarding muxes, the ALU-source mux and the ALU, and adds an iterative multiply/divide unit with architectural HI/LO registers. The unit raises a stall toward the hazard unit while a multi-cycle operation is in flight. It sits between the ID/EX and EX/MEM pipeline registers, and its outputs feed EX/MEM unregistered.

## Interface
Parameters:
- `WIDTH`, 32, datapath width; must be even and ≥ 8.
- `NFWD`, 2, number of forwarding sources (slot 0 = MEM, slot 1 = WB, further slots for deeper pipelines).
- `SELW`, `$clog2(NFWD+1)`, forward-select width (derived).
- `SHW`, `$clog2(WIDTH)`, shift-amount width (derived).

Ports:
- `clk`  in  1  — system clock. One clock domain; all state updates on the rising edge.
- `rst`  in  1  — synchronous, active-low reset.
- `read_data1`, `read_data2`  in  WIDTH  — register-file operands.
- `fwd_data`  in  NFWD*WIDTH  — forwarding buses; slot k occupies bits [k*WIDTH +: WIDTH].
- `fwd_sel_a`, `fwd_sel_b`  in  SELW  — source selects.
  - 0 = register file.
  - k = slot k-1.
  - Values above NFWD = zero.
- `ext_imm`  in  WIDTH  — sign/zero-extended immediate.
- `alu_src`  in  1  — 1 = `ext_imm` drives ALU operand 2.
- `alu_op`  in  4  — ALU operation; encoding is unchanged from the existing ALU.
- `shamt`  in  SHW  — shift amount.
- `md_start`  in  1  — a mult/div-class instruction is in EX this cycle.
- `md_op`  in  3  — mult/div operation select:
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU
  - 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO
- `flush`  in  1  — kill the in-flight mult/div operation.
- `alu_result`  out  WIDTH  — ALU result, or HI/LO on MFHI/MFLO.
- `forward_b`  out  WIDTH  — forwarded operand B (store data).
- `md_busy`  out  1  — an iterative operation is in progress.
- `stall`  out  1  — the EX stage must hold.

## Operation
- Forwarding: operands A and B each pass through an (NFWD+1):1 mux. A feeds ALU operand 1. B feeds `forward_b` and the `alu_src` mux.
- `alu_result` is combinational from the ALU, except when `md_start` is high with `md_op` 6 or 7: then it is HI or LO, taken from the registered value.
- The MDU FSM has two states, IDLE and RUN, plus a counter `cnt` of width SHW+1.
- IDLE, `md_start` with op 0–3: latch operand A (dividend/multiplicand), B, the sign flags and the op, then go to RUN with `cnt=0`.
  - Signed ops work on magnitudes; the result signs are fixed up at completion.
- IDLE, op 4/5: HI/LO ← A at the clock edge; 1-cycle, no stall.
- RUN: one shift-add (multiply) or restoring-subtract (divide) step per cycle. After WIDTH steps, write HI/LO and return to IDLE.
  - Multiply: {HI,LO} = full 2·WIDTH product.
  - Divide: LO = quotient, HI = remainder. The remainder takes the sign of the dividend; the quotient truncates toward zero.
  - Divide by zero: LO = all ones, HI = dividend. No trap.
  - DIV of the most-negative value by −1: LO = most-negative value, HI = 0.
- `stall` = `md_busy & md_start`. Any mult/div-class instruction in EX, including MFHI/MFLO, waits for completion. While stalled, the request is not consumed.
- Priority, highest first:
  1. Reset.
  2. `flush`: RUN→IDLE, HI/LO unchanged, any same-cycle start ignored.
  3. Completion write.
  4. New start.

## Timing
- Reset (`rst`=0 at the edge): state IDLE, `cnt`=0, HI=LO=0, `md_busy`=0.
- Reset mid-operation aborts it and zeroes HI/LO.
- Start accepted at edge E0. `md_busy`=1 from after E0 through the cycle preceding edge E_WIDTH. HI/LO are valid after E_WIDTH, so the latency is WIDTH cycles.
- An MFLO issued back-to-back stalls for WIDTH cycles and then reads the new value in the cycle `md_busy` falls.
- The forwarding/ALU path is purely combinational, with 0-cycle latency.

## Structure
- Shared package `cpu_pkg` holds:
  - `md_op_t` enum (the 8 encodings above);
  - the `alu_op` localparams;
  - the forward-select constants (`FWD_RF`=0, `FWD_MEM`=1, `FWD_WB`=2).
- Sub-module `md_unit` (parameter WIDTH) contains the FSM, counter, HI/LO and the fixup logic.
- Top level: instantiate `md_unit` and the existing ALU; generate the forwarding muxes; contains no other state.

## Test plan
- Forwarding, WIDTH=32:
  - `fwd_sel_a`=1 with slot0=0x10, `fwd_sel_b`=2 with slot1=0x5, ADD → `alu_result`=0x15, `forward_b`=0x5.
  - `fwd_sel_a`=3 → operand A = 0.
- MULT −3 × 7 → after 32 cycles, HI=0xFFFFFFFF, LO=0xFFFFFFEB; `md_busy` high for exactly 32 cycles.
- DIV −7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 / 0 → LO=0xFFFFFFFF, HI=7.
- MULTU followed immediately by MFLO → `stall` high for 32 cycles; then `alu_result`=product low word, and `stall` drops.
- `flush` at cycle 10 of a DIV → `md_busy` low next cycle, HI/LO keep their prior MTHI/MTLO values 0xA/0xB.
- `rst`=0 at cycle 5 of a MULT → HI=LO=0, `md_busy`=0. With WIDTH=16 and NFWD=3, MULT 0x7FFF×2 → {HI,LO}=0x0000_FFFE.
